// File: rtl/calc_pkg.sv
// Shared opcode and FSM encodings for the calculator arithmetic engine.
package calc_pkg;

  typedef logic [2:0] op_t;
  localparam op_t OP_ADD = 3'b000;
  localparam op_t OP_SUB = 3'b001;
  localparam op_t OP_MUL = 3'b010;
  localparam op_t OP_DIV = 3'b011;
  localparam op_t OP_MOD = 3'b100;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_DIV  = 2'd2;
  localparam state_t ST_FIN  = 2'd3;

  localparam logic [15:0] DIV0_DEFAULT = 16'hDEAD;

  typedef struct packed {
    logic div_by_zero;
    logic carry;
    logic err;
  } flags_t;

  function automatic logic is_div_op(input op_t op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first, W iterations after load.
module seq_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         last
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_dvs;
  logic [CW-1:0] r_cnt;

  logic [W:0] w_shift;
  logic [W:0] w_trial;
  logic       w_fits;

  // Partial remainder stays below the divisor, so a failed trial always borrows into bit W.
  assign w_shift = {r_rem, r_quo[W-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_fits  = ~w_trial[W];

  // NOTE: every register here, including the datapath, is cleared by reset so an abort leaves no stale iteration running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_quo <= dividend;
      r_rem <= '0;
      r_dvs <= divisor;
      r_cnt <= CW'(W);
    end else if (r_cnt != '0) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      r_rem <= w_fits ? w_trial[W-1:0] : w_shift[W-1:0];
      r_quo <= {r_quo[W-2:0], w_fits};
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign last      = (r_cnt == CW'(1));

endmodule

// File: rtl/calc_core.sv
// Handshaked calculator engine: add/sub/mul in one cycle, div/mod through the sequential divider.
module calc_core
  import calc_pkg::*;
#(
  parameter int          W          = 8,
  parameter logic [15:0] DIV0_VALUE = DIV0_DEFAULT
) (
  input  logic           CLK100MHZ,
  input  logic           reset,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           chain,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           div_by_zero,
  output logic           carry,
  output logic           zero,
  output logic           err
);

  localparam int             DW       = 2 * W;
  localparam logic [DW-1:0]  DIV0_EXT = DW'(DIV0_VALUE);

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  op_t           r_op;
  logic          r_dz;
  logic [DW-1:0] r_pend_res;
  flags_t        r_pend_flags;
  logic [DW-1:0] r_result;
  logic          r_done;
  flags_t        r_flags;
  logic          r_zero;

  logic [W-1:0]  w_a_sel;
  logic          w_accept;
  logic          w_div_load;
  logic [W:0]    w_sum;
  logic [W:0]    w_diff;
  logic [DW-1:0] w_prod;
  logic [W-1:0]  w_quo;
  logic [W-1:0]  w_rem;
  logic          w_div_last;
  logic [DW-1:0] w_fin_res;
  flags_t        w_fin_flags;

  assign w_a_sel    = chain ? r_result[W-1:0] : a;
  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_div_load = w_accept && is_div_op(op) && (b != '0);

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};
  assign w_prod = DW'(r_a) * DW'(r_b);

  seq_divider #(.W(W)) u_div (
    .clk       (CLK100MHZ),
    .rst       (reset),
    .load      (w_div_load),
    .dividend  (w_a_sel),
    .divisor   (b),
    .quotient  (w_quo),
    .remainder (w_rem),
    .last      (w_div_last)
  );

  // Divider results are read straight off the divider; everything else was staged in EXEC.
  always_comb begin
    w_fin_res   = r_pend_res;
    w_fin_flags = r_pend_flags;
    if (is_div_op(r_op) && !r_dz) begin
      w_fin_res   = {{W{1'b0}}, (r_op == OP_DIV) ? w_quo : w_rem};
      w_fin_flags = '0;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= OP_ADD;
      r_dz         <= 1'b0;
      r_pend_res   <= '0;
      r_pend_flags <= '0;
      r_result     <= '0;
      r_done       <= 1'b0;
      r_flags      <= '0;
      r_zero       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= w_a_sel;
            r_b     <= b;
            r_op    <= op;
            r_dz    <= is_div_op(op) && (b == '0);
            r_state <= w_div_load ? ST_DIV : ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (r_op)
            OP_ADD: begin
              r_pend_res   <= DW'(w_sum);
              r_pend_flags <= flags_t'{1'b0, w_sum[W], 1'b0};
            end
            OP_SUB: begin
              r_pend_res   <= {{W{1'b0}}, w_diff[W-1:0]};
              r_pend_flags <= flags_t'{1'b0, w_diff[W], 1'b0};
            end
            OP_MUL: begin
              r_pend_res   <= w_prod;
              r_pend_flags <= '0;
            end
            OP_DIV, OP_MOD: begin
              r_pend_res   <= DIV0_EXT;
              r_pend_flags <= flags_t'{1'b1, 1'b0, 1'b0};
            end
            default: begin
              r_pend_res   <= r_result;
              r_pend_flags <= flags_t'{1'b0, 1'b0, 1'b1};
            end
          endcase
          r_state <= ST_FIN;
        end
        ST_DIV: begin
          if (w_div_last) r_state <= ST_FIN;
        end
        ST_FIN: begin
          r_result <= w_fin_res;
          r_flags  <= w_fin_flags;
          r_zero   <= (w_fin_res == '0);
          r_done   <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign result      = r_result;
  assign div_by_zero = r_flags.div_by_zero;
  assign carry       = r_flags.carry;
  assign zero        = r_zero;
  assign err         = r_flags.err;

endmodule

// File: tb/tb_calc_core.sv
// Directed bench for calc_core at W=8 with hand-computed expected results and latencies.
module tb_calc_core;
  import calc_pkg::*;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [2:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           chain;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           div_by_zero;
  logic           carry;
  logic           zero;
  logic           err;

  int errors = 0;
  int checks = 0;

  calc_core #(.W(W), .DIV0_VALUE(16'hDEAD)) dut (
    .CLK100MHZ   (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .chain       (chain),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero),
    .carry       (carry),
    .zero        (zero),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {div_by_zero, carry, zero, err}.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] va,
                        input logic [7:0] vb, input logic ch, input int exp_lat,
                        input logic [15:0] exp_res, input logic [3:0] exp_flags);
    int lat;
    @(negedge clk);
    op = o; a = va; b = vb; chain = ch; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = OP_ADD; a = 8'h5A; b = 8'hA5; chain = 1'b0;
    check($sformatf("%s.busy_at_accept", tag), 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("%s.latency", tag), 32'(lat), 32'(exp_lat));
    check($sformatf("%s.result", tag), 32'(result), 32'(exp_res));
    check($sformatf("%s.flags", tag), 32'({div_by_zero, carry, zero, err}), 32'(exp_flags));
    check($sformatf("%s.busy_at_done", tag), 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check($sformatf("%s.done_one_cycle", tag), 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dones;
    int first_done;

    reset = 1'b1; start = 1'b0; op = OP_ADD; a = '0; b = '0; chain = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.result", 32'(result), 32'h0);
    check("reset.busy", 32'(busy), 32'h0);
    check("reset.done", 32'(done), 32'h0);
    check("reset.flags", 32'({div_by_zero, carry, zero, err}), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op("chain_after_reset", OP_ADD, 8'd99, 8'd5, 1'b1, 2, 16'h0005, 4'b0000);
    run_op("add_200_100", OP_ADD, 8'd200, 8'd100, 1'b0, 2, 16'h012C, 4'b0100);
    run_op("sub_5_7", OP_SUB, 8'd5, 8'd7, 1'b0, 2, 16'h00FE, 4'b0100);
    run_op("sub_7_7", OP_SUB, 8'd7, 8'd7, 1'b0, 2, 16'h0000, 4'b0010);
    run_op("mul_255_255", OP_MUL, 8'd255, 8'd255, 1'b0, 2, 16'hFE01, 4'b0000);
    run_op("div_200_7", OP_DIV, 8'd200, 8'd7, 1'b0, 9, 16'h001C, 4'b0000);
    run_op("mod_200_7", OP_MOD, 8'd200, 8'd7, 1'b0, 9, 16'h0004, 4'b0000);
    run_op("div_9_0", OP_DIV, 8'd9, 8'd0, 1'b0, 2, 16'hDEAD, 4'b1000);
    run_op("illegal_110", 3'b110, 8'd1, 8'd1, 1'b0, 2, 16'hDEAD, 4'b0001);
    run_op("add_3_4", OP_ADD, 8'd3, 8'd4, 1'b0, 2, 16'h0007, 4'b0000);
    run_op("chain_mul_6", OP_MUL, 8'd99, 8'd6, 1'b1, 2, 16'h002A, 4'b0000);

    // Start pulsed while a divide is running must be dropped.
    @(negedge clk);
    op = OP_DIV; a = 8'd100; b = 8'd10; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dones = 0;
    first_done = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start = (i == 2) || (i == 3);
      op = OP_ADD; a = 8'd1; b = 8'd1;
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        if (first_done < 0) first_done = i;
      end
    end
    check("ignore_busy.done_count", 32'(dones), 32'd1);
    check("ignore_busy.done_edge", 32'(first_done), 32'd8);
    check("ignore_busy.result", 32'(result), 32'h000A);

    // Start held high with chain: one op per three cycles, each chaining the previous result.
    @(negedge clk);
    op = OP_ADD; a = 8'd0; b = 8'd1; chain = 1'b1; start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
    check("b2b.first_latency", 32'(n), 32'd3);
    check("b2b.first_result", 32'(result), 32'h000B);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 40);
    start = 1'b0; chain = 1'b0;
    check("b2b.spacing", 32'(n), 32'd3);
    check("b2b.second_result", 32'(result), 32'h000C);
    @(posedge clk);
    #1;
    check("b2b.no_third_accept", 32'(busy), 32'd0);

    // Asynchronous reset during the fourth divider iteration.
    @(negedge clk);
    op = OP_DIV; a = 8'd250; b = 8'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort.result", 32'(result), 32'h0);
    check("abort.busy", 32'(busy), 32'h0);
    check("abort.done", 32'(done), 32'h0);
    check("abort.flags", 32'({div_by_zero, carry, zero, err}), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("abort.no_done", 32'(dones), 32'd0);
    run_op("add_1_1_after_abort", OP_ADD, 8'd1, 8'd1, 1'b0, 2, 16'h0002, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_core.md
# calc_core

Parametrised, handshaked arithmetic engine for the Nexys A7 embedded calculator, replacing the combinational 8-bit ALU and result latch. It accepts two W-bit operands and an opcode on a `start` pulse and computes add, sub, mul, div or mod. Division and modulo use a multi-cycle restoring divider. A chain mode feeds the previous result back as operand A. The block sits between the operand/button FSM and the seven-segment display path; `result` drives the display value directly.

## Interface
- `W`, 8: operand width; legal range 4..16.
- `DIV0_VALUE`, 16'hDEAD: pattern reported on divide/mod by zero, truncated or zero-extended to 2W.

- `CLK100MHZ`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 MOD, 101–111 illegal
- `a`, `b`  in  W  operands, unsigned
- `chain`  in  1  at accept, use `result[W-1:0]` as A instead of `a`
- `busy`  out  1  high from accept until `done`
- `done`  out  1  one-cycle pulse, result and flags valid
- `result`  out  2W  last completed result, held between operations
- `div_by_zero`, `carry`, `zero`, `err`  out  1 each  status of the last completed operation

## Operation
- FSM states: IDLE, EXEC, DIV, FIN.
  - IDLE -> EXEC on `start` when op ∈ {ADD, SUB, MUL}, on an illegal op, or on DIV/MOD with `b`==0.
  - IDLE -> DIV on `start` for DIV/MOD with `b`≠0.
  - EXEC -> FIN after 1 cycle.
  - DIV -> FIN after exactly W iterations, MSB first.
  - FIN -> IDLE unconditionally.
- At accept, the operands, opcode and chain-selected A are captured. Later changes on the inputs have no effect.
- ADD: `result` = zero-extended A+B (W+1 bits); `carry` = bit W.
- SUB: `result` = {W'b0, (A−B) mod 2^W}; `carry` = borrow (A<B).
- MUL: `result` = full 2W-bit product; `carry` = 0.
- DIV: `result` = {W'b0, quotient}. MOD: `result` = {W'b0, remainder}. `carry` = 0 for both.
- B==0 on DIV/MOD: `result` = DIV0_VALUE, `div_by_zero` = 1, and no iteration.
- Illegal op: `result` holds its previous value, `err` = 1, and `done` still pulses.
- `zero` = (`result`==0) after the update. All flags update only in FIN and hold until the next FIN.
- `start` during `busy` is ignored, not queued.

## Timing
- Reset: state IDLE. `result`, `busy`, `done` and all flags are 0. The chain source is 0.
- Let accept occur at edge k.
  - `busy` rises at edge k.
  - ADD/SUB/MUL/illegal/div-by-zero: result registered at edge k+1, `done`=1 and `busy`=0 from edge k+2 for exactly one cycle.
  - DIV/MOD: iterations at edges k+1..k+W, `done` from edge k+W+1.
- `start` held high continuously: a new accept occurs on the first IDLE cycle after `done`, which is back-to-back at one op per (latency+1) cycles.
- Reset asserted mid-DIV aborts immediately and asynchronously. No `done` is produced for the aborted operation.
- Chain uses the value of `result` at the accept edge, including a result completed in the immediately preceding FIN.

## Structure
- Package `calc_pkg` holds:
  - the op encodings (`OP_ADD` … `OP_MOD`) as a 3-bit typedef;
  - the state typedef;
  - the DIV0 default.
- Sub-module `seq_divider`: W-iteration restoring divider with `load`, `dividend`, `divisor`, `quotient`, `remainder` and `last`. It is instantiated once.
- Add, sub and mul stay inline in `calc_core`.

## Test plan (W=8)
- ADD a=200, b=100 -> `done` 2 cycles after accept, `result`=0x012C, `carry`=1, `zero`=0.
- SUB a=5, b=7 -> `result`=0x00FE, `carry`=1. SUB a=7, b=7 -> `result`=0, `zero`=1.
- MUL a=255, b=255 -> `result`=0xFE01. DIV a=200, b=7 -> `result`=0x001C, `done` at accept+9 edges. MOD a=200, b=7 -> `result`=0x0004.
- DIV a=9, b=0 -> `result`=0xDEAD, `div_by_zero`=1, latency 2. Op 110 -> `err`=1, `result` unchanged.
- Chain sequence ADD 3+4, then chain MUL b=6 -> `result`=0x002A. `start` pulsed while busy is ignored, with exactly one `done` per accept.
- Reset asserted at iteration 4 of DIV 250/3 -> all outputs 0 immediately, no `done`. Next ADD 1+1 completes normally with `result`=2.
